// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the mikroBUS GPIO interrupt front end.
// Register offsets are word indices taken from iomem_addr[7:2].
package gpio_irq_pkg;

  localparam int unsigned NUM_GPIO_MAX = 32;

  localparam logic [5:0] OFF_IN   = 6'h00;  // byte offset 0x00
  localparam logic [5:0] OFF_RISE = 6'h01;  // byte offset 0x04
  localparam logic [5:0] OFF_FALL = 6'h02;  // byte offset 0x08
  localparam logic [5:0] OFF_PEND = 6'h03;  // byte offset 0x0C
  localparam logic [5:0] OFF_MASK = 6'h04;  // byte offset 0x10
  localparam logic [5:0] OFF_DEB  = 6'h05;  // byte offset 0x14

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Byte-strobed update of a 32-bit register.
  function automatic logic [31:0] wr_merge(input logic [31:0] cur,
                                           input logic [31:0] wd,
                                           input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (cur & ~m) | (wd & m);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Optional input filter: a 16-bit prescaler produces a sample tick and each
// pin keeps a 3-deep history; the filtered level follows only when all three
// samples agree. Instantiated only when GPIO_IRQ_DEBOUNCE_EN is defined.
module gpio_debounce
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_GPIO = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [15:0]         i_div,
  input  logic                i_div_wr,
  input  logic [NUM_GPIO-1:0] i_level,
  output logic [NUM_GPIO-1:0] o_level
);

  logic [15:0]         r_cnt;
  logic                w_tick;
  logic [NUM_GPIO-1:0] r_h0, r_h1, r_h2;
  logic [NUM_GPIO-1:0] r_filt;
  logic [NUM_GPIO-1:0] w_all1, w_all0;

  // A divider write restarts the count and suppresses the tick that cycle.
  assign w_tick = !i_div_wr && (r_cnt == i_div);
  assign w_all1 = r_h0 & r_h1 & r_h2;
  assign w_all0 = ~(r_h0 | r_h1 | r_h2);
  assign o_level = r_filt;

  // Prescaler: count up to the divider value, then wrap to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_cnt <= '0;
    else if (i_div_wr || w_tick) r_cnt <= '0;
    else                         r_cnt <= r_cnt + 16'd1;
  end

  // Shift the synchronised level into the per-pin history on each tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h0 <= '0;
      r_h1 <= '0;
      r_h2 <= '0;
    end else if (w_tick) begin
      r_h2 <= r_h1;
      r_h1 <= r_h0;
      r_h0 <= i_level;
    end
  end

  // Filtered level moves only on unanimous history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_filt <= '0;
    else          r_filt <= (r_filt | w_all1) & ~w_all0;
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt front end on the picosoc iomem bus: 2-FF input sync,
// per-pin rise/fall detection into sticky W1C pending bits, and a registered
// level interrupt for irq_5. Define GPIO_IRQ_DEBOUNCE_EN to insert the
// gpio_debounce filter and enable the DEB_DIV register.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_GPIO = 10,
  parameter logic [7:0]  ADDR_HI  = 8'h04
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_di,
  output logic                irq
);

  // Registers are kept 32 bits wide; bits at and above NUM_GPIO are forced 0.
  localparam logic [31:0] GPIO_MASK = 32'((64'd1 << NUM_GPIO) - 64'd1);

  logic [NUM_GPIO-1:0] r_sync1, r_sync2;
  logic [31:0]         r_prev;
  logic [31:0]         r_rise_en, r_fall_en, r_pend, r_mask;
  logic                r_ready, r_irq;
  logic [31:0]         r_rdata;

  logic                w_sel, w_wr;
  logic [5:0]          w_off;
  logic [31:0]         w_lvl, w_rise, w_fall, w_clr, w_rd_mux, w_deb_rd;
  logic                w_unused_addr;

  assign w_sel = iomem_valid && !r_ready && (iomem_addr[31:24] == ADDR_HI);
  assign w_wr  = |iomem_wstrb;
  assign w_off = iomem_addr[7:2];
  assign w_unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [15:0]         r_deb_div;
  logic [NUM_GPIO-1:0] w_filt;
  logic                w_deb_wr;

  assign w_deb_wr = w_sel && w_wr && (w_off == OFF_DEB);
  assign w_deb_rd = {16'h0000, r_deb_div};

  gpio_debounce #(.NUM_GPIO(NUM_GPIO)) u_deb (
    .i_clk    (clk),
    .i_rst_n  (resetn),
    .i_div    (r_deb_div),
    .i_div_wr (w_deb_wr),
    .i_level  (r_sync2),
    .o_level  (w_filt)
  );

  // Debounce divider register, byte-strobed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_deb_div <= '0;
    end else if (w_deb_wr) begin
      if (iomem_wstrb[0]) r_deb_div[7:0]  <= iomem_wdata[7:0];
      if (iomem_wstrb[1]) r_deb_div[15:8] <= iomem_wdata[15:8];
    end
  end

  // Edge detection and IN both see the filtered level.
  always_comb begin
    w_lvl = '0;
    w_lvl[NUM_GPIO-1:0] = w_filt;
  end
`else
  assign w_deb_rd = '0;

  // Edge detection and IN see the synchronised level directly.
  always_comb begin
    w_lvl = '0;
    w_lvl[NUM_GPIO-1:0] = r_sync2;
  end
`endif

  assign w_rise = w_lvl & ~r_prev & r_rise_en;
  assign w_fall = ~w_lvl & r_prev & r_fall_en;
  assign w_clr  = (w_sel && w_wr && (w_off == OFF_PEND))
                  ? (iomem_wdata & strb_mask(iomem_wstrb)) : '0;

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_di;
      r_sync2 <= r_sync1;
    end
  end

  // One-cycle history of the monitored level for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_prev <= '0;
    else         r_prev <= w_lvl;
  end

  // Read data multiplexer (sampled on the edge that raises ready).
  always_comb begin
    w_rd_mux = '0;
    unique case (w_off)
      OFF_IN:   w_rd_mux = w_lvl;
      OFF_RISE: w_rd_mux = r_rise_en;
      OFF_FALL: w_rd_mux = r_fall_en;
      OFF_PEND: w_rd_mux = r_pend;
      OFF_MASK: w_rd_mux = r_mask;
      OFF_DEB:  w_rd_mux = w_deb_rd;
      default:  w_rd_mux = '0;
    endcase
  end

  // Bus handshake: single-cycle ready pulse, rdata held when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_sel;
      if (w_sel) r_rdata <= w_rd_mux;
    end
  end

  // Byte-strobed RW configuration registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_mask    <= '0;
    end else if (w_sel && w_wr) begin
      if (w_off == OFF_RISE)
        r_rise_en <= wr_merge(r_rise_en, iomem_wdata, iomem_wstrb) & GPIO_MASK;
      if (w_off == OFF_FALL)
        r_fall_en <= wr_merge(r_fall_en, iomem_wdata, iomem_wstrb) & GPIO_MASK;
      if (w_off == OFF_MASK)
        r_mask    <= wr_merge(r_mask, iomem_wdata, iomem_wstrb) & GPIO_MASK;
    end
  end

  // Sticky pending bits: a new edge wins over a simultaneous W1C.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pend <= '0;
    else         r_pend <= ((r_pend & ~w_clr) | w_rise | w_fall) & GPIO_MASK;
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= |(r_pend & r_mask);
  end

endmodule
